seg7_display_arbiter: RTL and testbench
=======================================

Name: seg7_display_arbiter

Overview:
Shares the 4-digit seven-segment display between two requesters: requester 0 is the CPU MMIO port and requester 1 is the debug/status port.
- Grants ownership only at frame boundaries, with a minimum hold time.
- Snapshots the owner's 16-bit hex value once per frame and time-multiplexes it onto the digits with a programmable refresh prescaler.
- Decodes hex to segments and drives AN/segment directly at the display pins.

Parameters:
REFRESH_DIV, 4, clk cycles per digit slot (>=1); frame = 4*REFRESH_DIV cycles
HOLD_FRAMES, 2, minimum completed frames an owner keeps the display before a contending requester may take it (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 wants the display (level)
val0  input  16  requester 0 hex value; nibble 3 goes to the leftmost digit
dp0  input  4  requester 0 decimal points, bit i goes to digit i
req1  input  1  requester 1 wants the display (level)
val1  input  16  requester 1 hex value
dp1  input  4  requester 1 decimal points
gnt  output  2  one-hot current owner; 2'b00 means idle
AN  output  4  one-hot digit enable, active-high; 4'b1000 = digit 3
segment  output  8  bit7 = dp, bits6:0 = gfedcba, active-high
frame_done  output  1  one-cycle pulse at each completed frame

Behaviour:
- Reset (async, immediate): AN=0, segment=0, gnt=0, frame_done=0, prescaler=0, state=IDLE, frames_held=0, last_gnt=1 (requester 0 wins the first tie).
- States:
  - IDLE: AN=0, segment=0, gnt=0.
  - SCAN: holds a digit index that runs 3,2,1,0.
- IDLE -> SCAN: evaluated every cycle.
  - If any req is sampled at edge k, then at edge k+1 the block shows gnt, AN=4'b1000, and the digit-3 segments.
  - Prescaler cleared.
  - Value/dp snapshot taken from the new owner at that same edge.
- Tie in IDLE (both req): grant the requester not equal to last_gnt.
- Prescaler: counts 0..REFRESH_DIV-1. The tick is prescaler==REFRESH_DIV-1. On tick the prescaler wraps to 0 and the digit index decrements; AN shifts right by one.
- Frame boundary = the tick while the digit index is 0. At that edge:
  - frame_done=1 for exactly one cycle.
  - frames_held increments, saturating at HOLD_FRAMES.
  - Arbitration decision (below).
  - Digit index returns to 3.
  - A new snapshot is taken from the (possibly new) owner.
- Arbitration at boundary (O = owner, X = other), with h = frames_held after increment:
  - O.req and (not X.req or h<HOLD_FRAMES): keep O.
  - else X.req: switch to X; gnt, last_gnt and snapshot change at this edge; frames_held=0.
  - else O.req: keep O.
  - else: go to IDLE; AN, segment and gnt become 0 at this edge.
- Mid-frame changes on req/val/dp are ignored until the next boundary, so there is no tearing and gnt changes only at a boundary or on the IDLE exit.
- segment is registered, derived from the snapshot nibble/dp for the active digit, and changes on the same edge as AN.
- Hex table:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - dp ORs bit7.
- REFRESH_DIV=1: a tick fires every cycle, so the digit advances every cycle.
- Reset asserted mid-frame: outputs clear immediately. After release, the block restarts from IDLE with no pending state.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - NUM_DIGITS=4;
  - AN_FIRST=4'b1000;
  - state enum {IDLE, SCAN}.
- Sub-module seg7_hex_decode: combinational, 4-bit nibble + dp in, 8-bit segment out; instantiated once on the selected nibble.

Test Plan:
(All scenarios use REFRESH_DIV=4, HOLD_FRAMES=2.)
- Reset then req0=1, val0=16'h12AF, dp0=0 -> next cycle gnt=01, AN=1000, segment=06 held 4 cycles; then AN=0100/5B, 0010/77, 0001/71; frame_done pulses once 16 cycles after the grant.
- From idle, raise req0 and req1 on the same edge -> gnt=01. After 2 frames gnt=10 at the boundary, and the value switches at that boundary.
- req0 owner, req1 rises in frame 1 -> the switch to gnt=10 happens at the end of frame 2, not frame 1; no gnt change mid-frame.
- Change val0 from 16'h0000 to 16'hFFFF mid-frame -> the remaining digits of the current frame show 3F; the next frame shows 71 on all digits.
- Drop req0 mid-frame with req1=0 -> scan completes the frame, then AN=0, segment=0, gnt=00 at the boundary edge.
- Assert rst during digit 1 -> AN, segment, gnt and frame_done go 0 asynchronously. After release with req1=1 -> gnt=10 one cycle later, starting at digit 3.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display arbiter: digit geometry,
// scan state encoding and the hex-to-segment table.
package seg7_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_FIRST   = 4'b1000;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Bits 6:0 = gfedcba, active-high; index is the hex nibble.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble, input logic dp);
        return {dp, HEX_SEG[nibble]};
    endfunction

endpackage

// File: rtl/seg7_display_arbiter_hex_decode.sv
// Combinational hex nibble plus decimal point to active-high segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    assign o_seg = hex_to_seg(i_nibble, i_dp);

endmodule

// File: rtl/seg7_display_arbiter.sv
// Two-requester arbiter for a 4-digit seven-segment display: frame-aligned
// ownership with minimum hold, per-frame value snapshot and digit multiplexing.
//
//   state | meaning
//   IDLE  | no owner, display dark
//   SCAN  | owner granted, digits scanned 3..0 from the frame snapshot
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 4,
    parameter int HOLD_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] val0,
    input  logic [3:0]  dp0,
    input  logic        req1,
    input  logic [15:0] val1,
    input  logic [3:0]  dp1,
    output logic [1:0]  gnt,
    output logic [3:0]  AN,
    output logic [7:0]  segment,
    output logic        frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int DW = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0] PS_LAST     = PW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_FRAMES);
    localparam logic [DW-1:0] DIGIT_FIRST = DW'(NUM_DIGITS - 1);

    state_t        r_state,       w_state_nxt;
    logic [PW-1:0] r_prescale,    w_prescale_nxt;
    logic [DW-1:0] r_digit,       w_digit_nxt;
    logic [1:0]    r_gnt,         w_gnt_nxt;
    logic          r_last_gnt,    w_last_gnt_nxt;
    logic [HW-1:0] r_held,        w_held_nxt;
    logic [15:0]   r_val,         w_val_nxt;
    logic [3:0]    r_dp,          w_dp_nxt;
    logic [3:0]    r_an,          w_an_nxt;
    logic          r_frame_done,  w_frame_done_nxt;
    logic [7:0]    r_seg;

    logic [1:0]    w_req;
    logic          w_tick;
    logic [HW-1:0] w_held_inc;
    logic          w_owner;
    logic          w_other;
    logic          w_sel;
    logic [3:0]    w_nibble;
    logic          w_dp_bit;
    logic [7:0]    w_seg_dec;

    assign w_req      = {req1, req0};
    assign w_tick     = (r_prescale == PS_LAST);
    assign w_held_inc = (r_held == HOLD_MAX) ? HOLD_MAX : r_held + 1'b1;
    // While scanning, the last granted requester is always the current owner.
    assign w_owner    = r_last_gnt;
    assign w_other    = ~r_last_gnt;

    always_comb begin
        w_state_nxt      = r_state;
        w_prescale_nxt   = r_prescale;
        w_digit_nxt      = r_digit;
        w_gnt_nxt        = r_gnt;
        w_last_gnt_nxt   = r_last_gnt;
        w_held_nxt       = r_held;
        w_val_nxt        = r_val;
        w_dp_nxt         = r_dp;
        w_an_nxt         = r_an;
        w_frame_done_nxt = 1'b0;
        w_sel            = 1'b0;

        case (r_state)
            IDLE: begin
                w_an_nxt  = 4'b0000;
                w_gnt_nxt = 2'b00;
                if (|w_req) begin
                    w_sel          = (&w_req) ? ~r_last_gnt : req1;
                    w_state_nxt    = SCAN;
                    w_prescale_nxt = '0;
                    w_digit_nxt    = DIGIT_FIRST;
                    w_an_nxt       = AN_FIRST;
                    w_gnt_nxt      = w_sel ? 2'b10 : 2'b01;
                    w_last_gnt_nxt = w_sel;
                    w_held_nxt     = '0;
                    w_val_nxt      = w_sel ? val1 : val0;
                    w_dp_nxt       = w_sel ? dp1 : dp0;
                end
            end
            SCAN: begin
                if (!w_tick) begin
                    w_prescale_nxt = r_prescale + 1'b1;
                end else begin
                    w_prescale_nxt = '0;
                    if (r_digit != '0) begin
                        w_digit_nxt = r_digit - 1'b1;
                        w_an_nxt    = r_an >> 1;
                    end else begin
                        w_frame_done_nxt = 1'b1;
                        w_digit_nxt      = DIGIT_FIRST;
                        w_an_nxt         = AN_FIRST;
                        if (w_req[w_owner] && (!w_req[w_other] || (w_held_inc < HOLD_MAX))) begin
                            w_held_nxt = w_held_inc;
                            w_val_nxt  = w_owner ? val1 : val0;
                            w_dp_nxt   = w_owner ? dp1 : dp0;
                        end else if (w_req[w_other]) begin
                            w_sel          = w_other;
                            w_gnt_nxt      = w_sel ? 2'b10 : 2'b01;
                            w_last_gnt_nxt = w_sel;
                            w_held_nxt     = '0;
                            w_val_nxt      = w_sel ? val1 : val0;
                            w_dp_nxt       = w_sel ? dp1 : dp0;
                        end else begin
                            w_state_nxt = IDLE;
                            w_gnt_nxt   = 2'b00;
                            w_an_nxt    = 4'b0000;
                            w_held_nxt  = '0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 2'b00;
                w_an_nxt    = 4'b0000;
            end
        endcase
    end

    // Decode from next-state values so segment updates on the same edge as AN.
    assign w_nibble = w_val_nxt[{w_digit_nxt, 2'b00} +: 4];
    assign w_dp_bit = w_dp_nxt[w_digit_nxt];

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .i_dp     (w_dp_bit),
        .o_seg    (w_seg_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_prescale   <= '0;
            r_digit      <= DIGIT_FIRST;
            r_gnt        <= 2'b00;
            r_last_gnt   <= 1'b1;
            r_held       <= '0;
            r_val        <= 16'h0000;
            r_dp         <= 4'h0;
            r_an         <= 4'b0000;
            r_frame_done <= 1'b0;
            r_seg        <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_prescale   <= w_prescale_nxt;
            r_digit      <= w_digit_nxt;
            r_gnt        <= w_gnt_nxt;
            r_last_gnt   <= w_last_gnt_nxt;
            r_held       <= w_held_nxt;
            r_val        <= w_val_nxt;
            r_dp         <= w_dp_nxt;
            r_an         <= w_an_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_seg        <= (w_state_nxt == SCAN) ? w_seg_dec : 8'h00;
        end
    end

    assign gnt        = r_gnt;
    assign AN         = r_an;
    assign segment    = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with REFRESH_DIV=4, HOLD_FRAMES=2.
module tb_seg7_display_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] val0, val1;
    logic [3:0]  dp0, dp1;
    logic [1:0]  gnt;
    logic [3:0]  AN;
    logic [7:0]  segment;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    seg7_display_arbiter #(.REFRESH_DIV(4), .HOLD_FRAMES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .val0       (val0),
        .dp0        (dp0),
        .req1       (req1),
        .val1       (val1),
        .dp1        (dp1),
        .gnt        (gnt),
        .AN         (AN),
        .segment    (segment),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] g, input logic [3:0] an,
                              input logic [7:0] seg, input logic fd);
        check({tag, ".gnt"}, 32'(gnt), 32'(g));
        check({tag, ".an"}, 32'(AN), 32'(an));
        check({tag, ".seg"}, 32'(segment), 32'(seg));
        check({tag, ".fd"}, 32'(frame_done), 32'(fd));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        expect_out("rst", 2'b00, 4'b0000, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    logic [7:0] seg_12af [4];

    initial begin
        rst  = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        val0 = 16'h0000; val1 = 16'h0000;
        dp0  = 4'h0; dp1 = 4'h0;
        seg_12af = '{8'h06, 8'h5B, 8'h77, 8'h71};

        // Basic scan of 12AF
        do_reset();
        step(1);
        expect_out("idle", 2'b00, 4'b0000, 8'h00, 1'b0);
        req0 = 1'b1; val0 = 16'h12AF;
        step(1);
        for (int i = 0; i < 16; i++) begin
            expect_out($sformatf("scan%0d", i), 2'b01, 4'b1000 >> (i / 4), seg_12af[i / 4], 1'b0);
            step(1);
        end
        expect_out("f1_end", 2'b01, 4'b1000, 8'h06, 1'b1);
        step(1);
        check("fd_one_cycle", 32'(frame_done), 32'd0);

        // Drop req0 mid-frame: frame completes, then dark
        step(3);
        req0 = 1'b0;
        step(11);
        expect_out("drop_last_digit", 2'b01, 4'b0001, 8'h71, 1'b0);
        step(1);
        expect_out("drop_boundary", 2'b00, 4'b0000, 8'h00, 1'b1);
        step(1);
        expect_out("drop_idle", 2'b00, 4'b0000, 8'h00, 1'b0);

        // Tie from reset: requester 0 first, switch after two frames
        do_reset();
        val0 = 16'h1111; val1 = 16'h2222;
        req0 = 1'b1; req1 = 1'b1;
        step(1);
        expect_out("tie_grant", 2'b01, 4'b1000, 8'h06, 1'b0);
        step(8);
        expect_out("tie_mid", 2'b01, 4'b0010, 8'h06, 1'b0);
        step(8);
        expect_out("tie_f1_end", 2'b01, 4'b1000, 8'h06, 1'b1);
        step(15);
        expect_out("tie_f2_last", 2'b01, 4'b0001, 8'h06, 1'b0);
        step(1);
        expect_out("tie_switch", 2'b10, 4'b1000, 8'h5B, 1'b1);

        // Late contender plus mid-frame value change
        do_reset();
        req1 = 1'b0; req0 = 1'b1; val0 = 16'h0000;
        step(1);
        expect_out("late_grant", 2'b01, 4'b1000, 8'h3F, 1'b0);
        step(5);
        expect_out("late_c5", 2'b01, 4'b0100, 8'h3F, 1'b0);
        val0 = 16'hFFFF; req1 = 1'b1; val1 = 16'h8888;
        step(3);
        expect_out("no_tear", 2'b01, 4'b0010, 8'h3F, 1'b0);
        step(4);
        expect_out("no_tear_d0", 2'b01, 4'b0001, 8'h3F, 1'b0);
        step(4);
        expect_out("late_f1_end", 2'b01, 4'b1000, 8'h71, 1'b1);
        step(7);
        expect_out("late_f2_mid", 2'b01, 4'b0100, 8'h71, 1'b0);
        step(8);
        expect_out("late_f2_last", 2'b01, 4'b0001, 8'h71, 1'b0);
        step(1);
        expect_out("late_switch", 2'b10, 4'b1000, 8'h7F, 1'b1);

        // Async reset during digit 1, then restart with requester 1
        step(9);
        expect_out("pre_rst_d1", 2'b10, 4'b0010, 8'h7F, 1'b0);
        rst = 1'b1;
        #1;
        expect_out("async_rst", 2'b00, 4'b0000, 8'h00, 1'b0);
        req0 = 1'b0; req1 = 1'b1; val1 = 16'hABCD; dp1 = 4'b1000;
        #1;
        rst = 1'b0;
        step(1);
        expect_out("restart_d3", 2'b10, 4'b1000, 8'hF7, 1'b0);
        step(4);
        expect_out("restart_d2", 2'b10, 4'b0100, 8'h7C, 1'b0);
        step(4);
        expect_out("restart_d1", 2'b10, 4'b0010, 8'h39, 1'b0);
        step(4);
        expect_out("restart_d0", 2'b10, 4'b0001, 8'h5E, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
